mux3_rr_arbiter: RTL and testbench
==================================

// Module: mux3_rr_arbiter
// PURPOSE
//   Shares one W-bit 3:1 mux datapath between three requesters (D0,D1,D2).
//   Round-robin arbitration; grant held while the owner keeps requesting.
//   Drives the mux selects S1/S0 and delivers the selected data registered,
//   with a valid flag. Sits between requesting sources and the shared consumer.
// PARAMETERS
//   W        = 1   data width of D0/D1/D2/Out
//   MAX_HOLD = 8   max consecutive grant cycles per owner (ARB_TIMEOUT_EN only); >=2
//   CNT_W    = 4   hold-counter width; must hold MAX_HOLD-1
// PORTS
//   clk      in   1   single clock, rising edge
//   rst      in   1   synchronous, active-high reset
//   req      in   3   req[i]=1: requester i wants the datapath
//   D0,D1,D2 in   W   requester data inputs
//   gnt      out  3   one-hot grant, registered; 000 when idle
//   S0,S1    out  1   mux select, registered: owner0=00, owner1=01, owner2=10 ({S1,S0})
//   Out      out  W   registered data of current owner
//   out_vld  out  1   Out holds owner data
//   busy     out  1   1 while in GRANT state
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, gnt=000, {S1,S0}=00, Out=0, out_vld=0,
//     busy=0, rr pointer=0 (priority order 0,1,2), hold counter=0.
//     Reset wins over every other event, including mid-grant.
//   States: IDLE, GRANT.
//   IDLE: if req!=000 at edge, pick first set req[i] scanning from ptr upward,
//     wrapping 2->0; set gnt[i]=1, {S1,S0}=enc(i), busy=1, go GRANT.
//     req=000: stay IDLE; gnt=000; {S1,S0} keep last value.
//   GRANT (owner k): if req[k]=1 stay GRANT, gnt unchanged.
//     If req[k]=0: gnt=000, busy=0, ptr=(k+1) mod 3 (2 wraps to 0), go IDLE.
//     No back-to-back grant: at least one IDLE cycle between owners.
//   Latency: req sampled at edge n -> gnt/S visible after edge n.
//   Data: every edge, out_vld <= (state==GRANT); Out <= D[owner] when state==GRANT,
//     else Out holds. out_vld therefore lags gnt by exactly 1 cycle.
//   Requests by non-owners during GRANT are ignored (not latched); they must stay high.
//   gnt never has more than one bit set; S1S0=11 never driven.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: hold counter clears on entry to GRANT, increments
//     each GRANT cycle, saturates at MAX_HOLD-1. At saturation, if any other req
//     is set, owner is preempted: same exit as release (gnt=000, ptr=k+1, IDLE).
//     If no other req pending, owner keeps grant, counter stays saturated.
//   ARB_TIMEOUT_EN undefined: no counter; owner keeps grant until req[k]=0.
// TESTING
//   (W=5, MAX_HOLD=4, check every cycle; model predicts gnt/S/Out/out_vld)
//   1 rst=1 then req=001,D0=5'h0A -> gnt=001,{S1,S0}=00 after 1st edge; Out=0A,out_vld=1 one edge later.
//   2 req=111 from reset, each owner drops after 2 cycles -> grant order 0,1,2,0; one IDLE cycle between each.
//   3 ptr=2 after owner 1 releases, req=101 -> gnt=100 ({S1,S0}=10), then after release gnt=001 (wrap).
//   4 owner 1 holding, D1=5'h13, rst=1 one cycle -> next cycle gnt=000,S=00,Out=0,out_vld=0,busy=0.
//   5 ARB_TIMEOUT_EN: req=011 held high -> owner0 4 cycles, preempted, owner1 4 cycles, owner0 ...
//     undefined: owner0 holds indefinitely (check 20 cycles).
//   6 random req/D for 1000 cycles vs reference model -> gnt one-hot or 0; S never 11; Out matches.

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one registered 3:1 mux between requesters D0/D1/D2.
// Optional feature: define ARB_TIMEOUT_EN to cap an owner's hold time at MAX_HOLD cycles.
module mux3_rr_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [W-1:0] D0,
  input  logic [W-1:0] D1,
  input  logic [W-1:0] D2,
  output logic [2:0]   gnt,
  output logic         S0,
  output logic         S1,
  output logic [W-1:0] Out,
  output logic         out_vld,
  output logic         busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

  state_t       state, state_nx;
  logic [1:0]   ptr, ptr_nx;
  logic [1:0]   sel, sel_nx;
  logic [2:0]   gnt_nx;
  logic [1:0]   pick;
  logic         preempt;
  logic [W-1:0] dsel;

  // First requester at or after p, wrapping 2->0; only meaningful when r != 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    case (p)
      2'd1:    rr_pick = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd2:    rr_pick = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: rr_pick = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nx;
  assign preempt = (cnt == HOLD_MAX) && |(req & ~gnt);
`else
  logic unused_cfg;
  assign preempt    = 1'b0;
  assign unused_cfg = ^HOLD_MAX;
`endif

  assign pick = rr_pick(req, ptr);
  assign busy = (state == GRANT);
  assign S1   = sel[1];
  assign S0   = sel[0];

  always_comb begin
    case (sel)
      2'd0:    dsel = D0;
      2'd1:    dsel = D1;
      default: dsel = D2;
    endcase
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    gnt_nx   = gnt;
`ifdef ARB_TIMEOUT_EN
    cnt_nx   = cnt;
`endif
    case (state)
      IDLE: begin
        gnt_nx = 3'b000;
        if (|req) begin
          state_nx = GRANT;
          sel_nx   = pick;
          gnt_nx   = 3'b001 << pick;
`ifdef ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      default: begin
        // sel holds the owner index throughout GRANT
        if (!(|(req & gnt)) || preempt) begin
          state_nx = IDLE;
          gnt_nx   = 3'b000;
          ptr_nx   = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt != HOLD_MAX) begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      sel     <= 2'd0;
      gnt     <= 3'b000;
      Out     <= '0;
      out_vld <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      sel     <= sel_nx;
      gnt     <= gnt_nx;
      out_vld <= (state == GRANT);
      if (state == GRANT) Out <= dsel;
`ifdef ARB_TIMEOUT_EN
      cnt     <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed and random bench for mux3_rr_arbiter; a cycle model feeds a scoreboard queue.
module tb_mux3_rr_arbiter;
  localparam int W        = 5;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   req = 3'b000;
  logic [W-1:0] D0 = '0, D1 = '0, D2 = '0;
  logic [2:0]   gnt;
  logic         S0, S1;
  logic [W-1:0] Out;
  logic         out_vld;
  logic         busy;

  always #5 clk = ~clk;

  mux3_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .D0(D0), .D1(D1), .D2(D2),
    .gnt(gnt), .S0(S0), .S1(S1), .Out(Out), .out_vld(out_vld), .busy(busy)
  );

  typedef struct packed {
    logic [2:0]   gnt;
    logic [1:0]   s;
    logic [W-1:0] out;
    logic         vld;
    logic         busy;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic             m_busy = 1'b0;
  logic [1:0]       m_own  = 2'd0;
  logic [1:0]       m_ptr  = 2'd0;
  logic [CNT_W-1:0] m_cnt  = '0;
  logic [2:0]       m_gnt  = 3'b000;
  logic [1:0]       m_s    = 2'd0;
  logic [W-1:0]     m_out  = '0;
  logic             m_vld  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [2:0] rq,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    int   pk;
    logic rel;
    if (r) begin
      m_busy = 1'b0; m_own = 2'd0; m_ptr = 2'd0; m_cnt = '0;
      m_gnt = 3'b000; m_s = 2'd0; m_out = '0; m_vld = 1'b0;
    end else begin
      if (m_busy) m_out = (m_own == 2'd0) ? a : (m_own == 2'd1) ? b : c;
      m_vld = m_busy;
      if (!m_busy) begin
        pk = -1;
        for (int k = 0; k < 3; k++)
          if (pk < 0 && rq[(int'(m_ptr) + k) % 3]) pk = (int'(m_ptr) + k) % 3;
        if (pk >= 0) begin
          m_own = 2'(pk); m_s = 2'(pk); m_gnt = 3'(1 << pk);
          m_busy = 1'b1; m_cnt = '0;
        end else begin
          m_gnt = 3'b000;
        end
      end else begin
        rel = !rq[m_own];
`ifdef ARB_TIMEOUT_EN
        if (!rel) begin
          if (int'(m_cnt) == MAX_HOLD - 1) begin
            if ((rq & ~m_gnt) != 3'b000) rel = 1'b1;
          end else begin
            m_cnt = m_cnt + 1'b1;
          end
        end
`endif
        if (rel) begin
          m_gnt = 3'b000; m_busy = 1'b0;
          m_ptr = (m_own == 2'd2) ? 2'd0 : m_own + 2'd1;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [2:0] rq,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; D0 = a; D1 = b; D2 = c;
    model_step(r, rq, a, b, c);
    e = '{gnt: m_gnt, s: m_s, out: m_out, vld: m_vld, busy: m_busy};
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("gnt",    32'(gnt),       32'(e.gnt));
    chk("sel",    32'({S1, S0}),  32'(e.s));
    chk("out",    32'(Out),       32'(e.out));
    chk("vld",    32'(out_vld),   32'(e.vld));
    chk("busy",   32'(busy),      32'(e.busy));
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
    chk("sel11",  32'({S1, S0} == 2'b11), 32'd0);
  endtask

  initial begin
    int         held;
    int         n001;
    logic [2:0] rq;
    logic [2:0] prev_gnt;
    logic [1:0] order[$];

    // reset state and single requester latency
    cyc(1'b1, 3'b000, '0, '0, '0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_vld", 32'(out_vld), 32'd0);
    cyc(1'b0, 3'b001, 5'h0A, '0, '0);
    chk("t1_gnt", 32'(gnt), 32'b001);
    chk("t1_sel", 32'({S1, S0}), 32'd0);
    chk("t1_vld_lag", 32'(out_vld), 32'd0);
    cyc(1'b0, 3'b001, 5'h0A, '0, '0);
    chk("t1_out", 32'(Out), 32'h0A);
    chk("t1_vld", 32'(out_vld), 32'd1);
    cyc(1'b0, 3'b000, 5'h0A, '0, '0);
    cyc(1'b0, 3'b000, 5'h0A, '0, '0);

    // all three requesting, each owner drops after two grant cycles
    cyc(1'b1, 3'b000, '0, '0, '0);
    held = 0;
    prev_gnt = 3'b000;
    for (int i = 0; i < 12; i++) begin
      rq = 3'b111;
      if (m_busy && held >= 2) rq[m_own] = 1'b0;
      cyc(1'b0, rq, 5'(i), 5'(i + 8), 5'(i + 16));
      if (gnt != 3'b000 && prev_gnt == 3'b000) order.push_back({S1, S0});
      prev_gnt = gnt;
      held = m_busy ? held + 1 : 0;
    end
    chk("t2_ngrants", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("t2_ord0", 32'(order[0]), 32'd0);
      chk("t2_ord1", 32'(order[1]), 32'd1);
      chk("t2_ord2", 32'(order[2]), 32'd2);
      chk("t2_ord3", 32'(order[3]), 32'd0);
    end

    // pointer at 2 after owner 1 releases, then wrap to 0
    cyc(1'b1, 3'b000, '0, '0, '0);
    cyc(1'b0, 3'b010, 5'h01, 5'h02, 5'h03);
    cyc(1'b0, 3'b010, 5'h01, 5'h02, 5'h03);
    cyc(1'b0, 3'b000, 5'h01, 5'h02, 5'h03);
    cyc(1'b0, 3'b101, 5'h01, 5'h02, 5'h03);
    chk("t3_gnt2", 32'(gnt), 32'b100);
    chk("t3_sel2", 32'({S1, S0}), 32'd2);
    cyc(1'b0, 3'b101, 5'h01, 5'h02, 5'h03);
    cyc(1'b0, 3'b001, 5'h01, 5'h02, 5'h03);
    cyc(1'b0, 3'b001, 5'h01, 5'h02, 5'h03);
    chk("t3_wrap", 32'(gnt), 32'b001);

    // reset in the middle of a grant
    cyc(1'b1, 3'b000, '0, '0, '0);
    cyc(1'b0, 3'b010, '0, 5'h13, '0);
    cyc(1'b0, 3'b010, '0, 5'h13, '0);
    cyc(1'b0, 3'b010, '0, 5'h13, '0);
    chk("t4_out", 32'(Out), 32'h13);
    cyc(1'b1, 3'b010, '0, 5'h13, '0);
    chk("t4_gnt", 32'(gnt), 32'd0);
    chk("t4_sel", 32'({S1, S0}), 32'd0);
    chk("t4_out0", 32'(Out), 32'd0);
    chk("t4_vld", 32'(out_vld), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);

    // two requesters held high: preemption or indefinite hold
    cyc(1'b1, 3'b000, '0, '0, '0);
    n001 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 3'b011, 5'h05, 5'h06, '0);
      if (gnt == 3'b001) n001++;
    end
`ifdef ARB_TIMEOUT_EN
    chk("t5_own0_cycles", 32'(n001), 32'd8);
`else
    chk("t5_own0_cycles", 32'(n001), 32'd20);
`endif

    // random traffic against the model
    for (int i = 0; i < 1000; i++)
      cyc(($urandom_range(63) == 0), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
